// File: rtl/conv_index_gen_if.sv
// Handshake and configuration bundle for the convolution index generator.
// The master side (config block / MAC control) drives the job request and
// the downstream ready; the slave side (the generator) returns the address
// pairs, term flags and job status.
interface conv_index_gen_if #(
    parameter int ADDR_W = 6
);
    logic              start_i;
    logic              mode_i;
    logic [ADDR_W-1:0] size_x_i;
    logic [ADDR_W-1:0] size_y_i;
    logic              ready_i;
    logic              valid_o;
    logic [ADDR_W-1:0] x_ptr_o;
    logic [ADDR_W-1:0] y_ptr_o;
    logic [ADDR_W:0]   z_ptr_o;
    logic              first_o;
    logic              last_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output start_i, mode_i, size_x_i, size_y_i, ready_i,
        input  valid_o, x_ptr_o, y_ptr_o, z_ptr_o, first_o, last_o, busy_o, done_o
    );

    modport slave (
        input  start_i, mode_i, size_x_i, size_y_i, ready_i,
        output valid_o, x_ptr_o, y_ptr_o, z_ptr_o, first_o, last_o, busy_o, done_o
    );
endinterface

// File: rtl/conv_index_gen.sv
// Convolution index generator: walks every output index i and, for each,
// every contributing tap k, emitting (x=k, y=i-k, z) address triples with
// first/last-term markers for the MAC. Supports full and same modes.
module conv_index_gen #(
    parameter int ADDR_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    conv_index_gen_if.slave  bus
);
    // Two extra bits hold Nx+Ny-2 and i+1 without wrap at maximum sizes.
    localparam int W2 = ADDR_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_mode;
    logic [W2-1:0]   r_nx;
    logic [W2-1:0]   r_ny;
    logic [W2-1:0]   r_i;
    logic [W2-1:0]   r_i_end;
    logic [W2-1:0]   r_off;
    logic [W2-1:0]   r_k;
    logic [W2-1:0]   r_kmin;
    logic [W2-1:0]   r_kmax;
    logic            r_valid;
    logic            r_busy;
    logic            r_done;

    logic [W2-1:0]   w_off;
    logic [W2-1:0]   w_i_end;
    logic [W2-1:0]   w_i_inc;
    logic            w_xfer;

    // Lowest tap index contributing to output i: max(0, i-Ny+1).
    function automatic logic [W2-1:0] f_kmin(input logic [W2-1:0] i, input logic [W2-1:0] ny);
        return ((i + W2'(1)) > ny) ? (i + W2'(1) - ny) : '0;
    endfunction

    // Highest tap index contributing to output i: min(i, Nx-1).
    function automatic logic [W2-1:0] f_kmax(input logic [W2-1:0] i, input logic [W2-1:0] nx);
        return (i < (nx - W2'(1))) ? i : (nx - W2'(1));
    endfunction

    // Same mode centres the window on Y; full mode starts at output 0.
    assign w_off   = r_mode ? ((r_ny - W2'(1)) >> 1) : '0;
    assign w_i_end = r_mode ? (w_off + r_nx - W2'(1)) : (r_nx + r_ny - W2'(2));
    assign w_i_inc = r_i + W2'(1);
    assign w_xfer  = r_valid & bus.ready_i;

    // Job sequencer: latch config, prime the first output, then step k and i
    // on each accepted beat with no bubble between outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= 1'b0;
            r_nx    <= '0;
            r_ny    <= '0;
            r_i     <= '0;
            r_i_end <= '0;
            r_off   <= '0;
            r_k     <= '0;
            r_kmin  <= '0;
            r_kmax  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        r_mode <= bus.mode_i;
                        r_nx   <= {2'b00, bus.size_x_i};
                        r_ny   <= {2'b00, bus.size_y_i};
                        if ((bus.size_x_i == '0) || (bus.size_y_i == '0)) begin
                            // Empty job: nothing to emit, report completion next cycle.
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    r_off   <= w_off;
                    r_i_end <= w_i_end;
                    r_i     <= w_off;
                    r_k     <= f_kmin(w_off, r_ny);
                    r_kmin  <= f_kmin(w_off, r_ny);
                    r_kmax  <= f_kmax(w_off, r_nx);
                    r_valid <= 1'b1;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_xfer) begin
                        if (r_k != r_kmax) begin
                            r_k <= r_k + W2'(1);
                        end else if (r_i != r_i_end) begin
                            r_i    <= w_i_inc;
                            r_k    <= f_kmin(w_i_inc, r_ny);
                            r_kmin <= f_kmin(w_i_inc, r_ny);
                            r_kmax <= f_kmax(w_i_inc, r_nx);
                        end else begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Address outputs are pure functions of the held registers, so they stay
    // stable while the consumer stalls; flags are qualified by valid.
    assign bus.valid_o = r_valid;
    assign bus.x_ptr_o = ADDR_W'(r_k);
    assign bus.y_ptr_o = ADDR_W'(r_i - r_k);
    assign bus.z_ptr_o = (ADDR_W + 1)'(r_i - r_off);
    assign bus.first_o = r_valid & (r_k == r_kmin);
    assign bus.last_o  = r_valid & (r_k == r_kmax);
    assign bus.busy_o  = r_busy;
    assign bus.done_o  = r_done;

endmodule

// File: tb/tb_conv_index_gen.sv
// Directed self-checking bench for conv_index_gen: full/same sequences,
// backpressure, edge sizes, abort by reset and start-while-busy.
module tb_conv_index_gen;
    localparam int ADDR_W = 6;
    localparam int LIMIT  = 20000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    conv_index_gen_if #(.ADDR_W(ADDR_W)) ifc ();

    conv_index_gen #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int q_beats[$];
    int exp_q[$];
    bit [3:0] rdy_pat = 4'b1001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int pk(input int x, input int y, input int z, input bit f, input bit l);
        return (x << 24) | (y << 16) | (z << 8) | (int'(f) << 1) | int'(l);
    endfunction

    function automatic int cur_beat();
        return pk(int'(ifc.x_ptr_o), int'(ifc.y_ptr_o), int'(ifc.z_ptr_o), ifc.first_o, ifc.last_o);
    endfunction

    // Launch one job, collect accepted beats, check latency and done timing.
    task automatic run_job(input bit mode, input int nx, input int ny, input bit bp,
                           input bit poke_busy, input bit verbose);
        int  cyc;
        int  lat;
        int  last_cyc;
        bit  got_done;
        bit  hold;
        int  prev;
        int  cur;
        bit  nonzero;
        logic [31:0] sx;
        logic [31:0] sy;
        sx = nx;
        sy = ny;
        nonzero = (nx != 0) && (ny != 0);
        q_beats.delete();
        lat = -1; last_cyc = 0; got_done = 0; hold = 0; prev = 0;
        @(negedge clk);
        ifc.start_i  = 1'b1;
        ifc.mode_i   = mode;
        ifc.size_x_i = sx[ADDR_W-1:0];
        ifc.size_y_i = sy[ADDR_W-1:0];
        ifc.ready_i  = 1'b1;
        @(negedge clk);
        // Config changes after the start edge must not affect the job.
        ifc.start_i  = 1'b0;
        ifc.mode_i   = ~mode;
        ifc.size_x_i = 6'd7;
        ifc.size_y_i = 6'd1;
        cyc = 1;
        while (!got_done && cyc < LIMIT) begin
            ifc.ready_i = bp ? rdy_pat[cyc % 4] : 1'b1;
            if (poke_busy && cyc == 4) begin
                ifc.start_i = 1'b1; ifc.size_x_i = 6'd5; ifc.size_y_i = 6'd5;
            end else if (poke_busy && cyc == 5) begin
                ifc.start_i = 1'b0;
            end
            if (ifc.done_o) begin
                got_done = 1'b1;
            end else begin
                if (cyc == 1 && nonzero) begin
                    check("load_busy", 32'(ifc.busy_o), 32'd1);
                    check("load_valid", 32'(ifc.valid_o), 32'd0);
                end
                if (ifc.valid_o) begin
                    cur = cur_beat();
                    if (lat < 0) lat = cyc;
                    if (hold) check("hold_stable", cur, prev);
                    if (ifc.ready_i) begin
                        q_beats.push_back(cur);
                        last_cyc = cyc;
                        hold = 1'b0;
                        if (verbose)
                            $display("beat %0d: x=%0d y=%0d z=%0d first=%0b last=%0b",
                                     q_beats.size(), ifc.x_ptr_o, ifc.y_ptr_o, ifc.z_ptr_o,
                                     ifc.first_o, ifc.last_o);
                    end else begin
                        hold = 1'b1;
                        prev = cur;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", 32'(got_done), 32'd1);
        if (nonzero) begin
            check("first_valid_latency", lat, 2);
            check("done_after_last", cyc, last_cyc + 1);
        end else begin
            check("empty_done_latency", cyc, 1);
            check("empty_no_valid", lat, -1);
        end
        check("done_cycle_valid", 32'(ifc.valid_o), 32'd0);
        check("done_cycle_busy", 32'(ifc.busy_o), 32'd0);
        $display("job mode=%0d nx=%0d ny=%0d: %0d beats, done at cycle %0d", mode, nx, ny,
                 q_beats.size(), cyc);
        // A start presented during the DONE cycle must be ignored.
        if (poke_busy) begin
            ifc.start_i = 1'b1; ifc.size_x_i = 6'd2; ifc.size_y_i = 6'd2;
        end
        @(negedge clk);
        ifc.start_i = 1'b0;
        check("done_one_cycle", 32'(ifc.done_o), 32'd0);
        check("idle_busy", 32'(ifc.busy_o), 32'd0);
        @(negedge clk);
        check("idle_valid", 32'(ifc.valid_o), 32'd0);
        check("idle_busy2", 32'(ifc.busy_o), 32'd0);
    endtask

    task automatic compare_seq(input string name, input int exp[$]);
        int n;
        check({name, "_count"}, q_beats.size(), exp.size());
        n = (q_beats.size() < exp.size()) ? q_beats.size() : exp.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", name, i), q_beats[i], exp[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(ifc.valid_o), 32'd0);
        check({tag, "_first"}, 32'(ifc.first_o), 32'd0);
        check({tag, "_last"},  32'(ifc.last_o),  32'd0);
        check({tag, "_busy"},  32'(ifc.busy_o),  32'd0);
        check({tag, "_done"},  32'(ifc.done_o),  32'd0);
        check({tag, "_x"},     32'(ifc.x_ptr_o), 32'd0);
        check({tag, "_y"},     32'(ifc.y_ptr_o), 32'd0);
        check({tag, "_z"},     32'(ifc.z_ptr_o), 32'd0);
    endtask

    int full32[$];
    int n_seen;
    int n_first;

    initial begin
        ifc.start_i  = 1'b0;
        ifc.mode_i   = 1'b0;
        ifc.size_x_i = '0;
        ifc.size_y_i = '0;
        ifc.ready_i  = 1'b1;
        full32 = '{pk(0,0,0,1,1), pk(0,1,1,1,0), pk(1,0,1,0,1),
                   pk(1,1,2,1,0), pk(2,0,2,0,1), pk(2,1,3,1,1)};

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Full 3x2, no backpressure.
        run_job(1'b0, 3, 2, 1'b0, 1'b0, 1'b1);
        compare_seq("full3x2", full32);

        // Same 3x3: off=1.
        run_job(1'b1, 3, 3, 1'b0, 1'b0, 1'b1);
        exp_q = '{pk(0,1,0,1,0), pk(1,0,0,0,1),
                  pk(0,2,1,1,0), pk(1,1,1,0,0), pk(2,0,1,0,1),
                  pk(1,2,2,1,0), pk(2,1,2,0,1)};
        compare_seq("same3x3", exp_q);

        // Backpressure on the full 3x2 job.
        run_job(1'b0, 3, 2, 1'b1, 1'b0, 1'b1);
        compare_seq("bp3x2", full32);

        // Empty job.
        run_job(1'b0, 0, 4, 1'b0, 1'b0, 1'b1);
        check("nx0_beats", q_beats.size(), 0);

        // Nx=1, Ny=4 full: one term per output.
        run_job(1'b0, 1, 4, 1'b0, 1'b0, 1'b1);
        exp_q = '{pk(0,0,0,1,1), pk(0,1,1,1,1), pk(0,2,2,1,1), pk(0,3,3,1,1)};
        compare_seq("full1x4", exp_q);

        // Maximum sizes.
        run_job(1'b0, 63, 63, 1'b0, 1'b0, 1'b0);
        check("max_beats", q_beats.size(), 3969);
        if (q_beats.size() > 0) begin
            check("max_first_beat", q_beats[0], pk(0,0,0,1,1));
            check("max_last_beat", q_beats[q_beats.size()-1], pk(62,62,124,1,1));
        end
        n_first = 0;
        foreach (q_beats[i]) if (q_beats[i][1]) n_first++;
        check("max_outputs", n_first, 125);

        // Abort by reset while the third beat of the full 3x2 job is presented.
        @(negedge clk);
        ifc.start_i = 1'b1; ifc.mode_i = 1'b0; ifc.size_x_i = 6'd3; ifc.size_y_i = 6'd2;
        ifc.ready_i = 1'b1;
        @(negedge clk);
        ifc.start_i = 1'b0;
        n_seen = 0;
        for (int c = 0; c < 50 && n_seen < 3; c++) begin
            @(negedge clk);
            if (ifc.valid_o) n_seen++;
        end
        check("abort_reached_beat3", n_seen, 3);
        check("abort_beat3_value", cur_beat(), full32[2]);
        $display("abort: asserting rst at beat %0d", n_seen);
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_no_done", 32'(ifc.done_o), 32'd0);
            check("abort_no_valid", 32'(ifc.valid_o), 32'd0);
        end
        run_job(1'b0, 3, 2, 1'b0, 1'b0, 1'b1);
        compare_seq("after_abort", full32);

        // Start pulses while busy and during DONE are ignored.
        run_job(1'b0, 3, 2, 1'b0, 1'b1, 1'b1);
        compare_seq("start_busy", full32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
